uart_rx_n: RTL
==============

UART_RX_N -- requirements
Module: uart_rx_n

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 5208, meaning Clock cycles per UART bit (50 MHz / 9600 baud); legal range 4..65535.
REQ-002 Clock  input  1  system clock; all state changes on rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 RX  input  1  serial line; idle high; 8N1 framing, LSB first.
REQ-005 Num  input  4  number of bytes to receive; values 9..15 treated as 8.
REQ-006 Trig_in  input  1  arm request; level-sampled only while idle=1.
REQ-007 Buffer  output  64  received bytes, right-justified.
REQ-008 idle  output  1  high when no reception is armed or in progress.
REQ-009 Done  output  1  one-cycle pulse: all Num bytes received.
REQ-010 Err  output  1  one-cycle pulse: framing error, transfer aborted.

Function
REQ-011 RX SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (2-cycle input latency).
REQ-012 States SHALL be IDLE, WAIT_START, START, DATA, STOP; the reset state is IDLE.
REQ-013 IDLE with Trig_in=1: latch Num (clamped) into the byte counter, clear Buffer to 0, deassert idle, go to WAIT_START next cycle.
REQ-014 IDLE with Trig_in=1 and clamped Num=0: pulse Done for one cycle, stay IDLE, leave Buffer cleared.
REQ-015 Trig_in SHALL be ignored outside IDLE; if held high, the block re-arms in the cycle after Done or Err.
REQ-016 WAIT_START: a synchronized RX=0 SHALL enter START and reset the bit-timer.
REQ-017 START: at timer = CLKS_PER_BIT/2 (integer division), resample RX; 0 -> DATA with timer reset; 1 -> WAIT_START (glitch rejected, no byte counted).
REQ-018 DATA: sample RX every CLKS_PER_BIT cycles after the start-bit midpoint; shift 8 bits LSB-first into a byte register; after bit 7 -> STOP.
REQ-019 STOP: sample at the stop-bit midpoint; RX=1 -> Buffer <= {Buffer[55:0], byte}, decrement the byte counter.
REQ-020 After a valid stop bit: counter now 0 -> pulse Done, set idle=1, go to IDLE; otherwise -> WAIT_START.
REQ-021 Stop bit sampled 0: pulse Err, discard the byte, keep the partial Buffer, set idle=1, go to IDLE.
REQ-022 Done and Err SHALL never assert in the same cycle; each is high for exactly one Clock.
REQ-023 The first received byte SHALL end in the most significant used byte, i.e. Buffer[8*N-1 -: 8] for N bytes; the last byte SHALL land in Buffer[7:0].
REQ-024 The bit-timer SHALL be wide enough for CLKS_PER_BIT-1 without wrap; the byte counter SHALL be 4 bits.
REQ-025 Buffer SHALL be stable, not shifting, between byte commits and after Done until the next arm.

Reset
REQ-026 Reset=0 SHALL asynchronously force state IDLE, Buffer=64'h0, idle=1, Done=0, Err=0, the counters and byte register to 0, and the synchronizer flops to 1.
REQ-027 Reset released mid-frame SHALL resume in IDLE; the remainder of the frame is ignored until re-armed and a new start bit arrives.

Verification (CLKS_PER_BIT=8, 20 ns Clock)
REQ-028 Reset: assert Reset=0 -> Buffer=0, idle=1, Done=0, Err=0 immediately, with no clock edge.
REQ-029 Num=8, Trig_in=1, send 12 34 56 78 90 12 34 56 -> one Done pulse, Buffer=64'h1234567890123456, idle=1.
REQ-030 Num=2, send A5 3C -> Buffer=64'h000000000000A53C, Done pulse; Num=0 -> Done one cycle after arm, Buffer=0.
REQ-031 Armed, RX low for 2 cycles then high -> no byte counted; following byte 55 (Num=1) -> Buffer=64'h55, Done.
REQ-032 Num=2, first byte with stop bit=0 -> Err pulse, no Done, idle=1, Buffer=0.
REQ-033 Reset pulse during bit 4 of byte 1 -> reset values; re-arm with Num=1 and send 0F -> Buffer=64'h0F, Done.

Source files
------------

// File: rtl/uart_rx_n.sv
// uart_rx_n: multi-byte 8N1 UART receiver.
// Once armed it collects up to eight bytes and shifts each one into a 64-bit
// right-justified buffer, so the first byte received is the most significant.
// Done pulses when the requested count has arrived; Err pulses on a bad stop bit.
module uart_rx_n #(
   parameter int unsigned CLKS_PER_BIT = 5208
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        RX,
   input  logic [3:0]  Num,
   input  logic        Trig_in,
   output logic [63:0] Buffer,
   output logic        idle,
   output logic        Done,
   output logic        Err
);

   localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] HALF_BIT = TW'(CLKS_PER_BIT / 2);
   localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_START,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t         state_q;
   logic           rx_meta_q;
   logic           rx_sync_q;
   logic [TW-1:0]  timer_q;
   logic [2:0]     bit_q;
   logic [3:0]     cnt_q;
   logic [7:0]     byte_q;
   logic [63:0]    buf_q;
   logic           idle_q;
   logic           done_q;
   logic           err_q;
   logic [3:0]     num_d;

   // Byte counts above eight are limited to the buffer capacity.
   always_comb begin
      num_d = Num;
      if (Num > 4'd8) begin
         num_d = 4'd8;
      end
   end

   // Two-flop synchronizer on the serial line; reset to the idle-high level.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
      end else begin
         rx_meta_q <= RX;
         rx_sync_q <= rx_meta_q;
      end
   end

   // Receiver FSM: start-bit qualification, mid-bit sampling, byte commit.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         bit_q   <= '0;
         cnt_q   <= '0;
         byte_q  <= '0;
         buf_q   <= '0;
         idle_q  <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (Trig_in) begin
                  cnt_q <= num_d;
                  buf_q <= '0;
                  if (num_d == 4'd0) begin
                     done_q <= 1'b1;
                  end else begin
                     idle_q  <= 1'b0;
                     state_q <= S_WAIT_START;
                  end
               end
            end
            S_WAIT_START: begin
               if (!rx_sync_q) begin
                  timer_q <= '0;
                  state_q <= S_START;
               end
            end
            S_START: begin
               if (timer_q == HALF_BIT) begin
                  timer_q <= '0;
                  if (!rx_sync_q) begin
                     bit_q   <= '0;
                     state_q <= S_DATA;
                  end else begin
                     state_q <= S_WAIT_START;
                  end
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            S_DATA: begin
               if (timer_q == LAST_TICK) begin
                  timer_q <= '0;
                  byte_q  <= {rx_sync_q, byte_q[7:1]};
                  bit_q   <= bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     state_q <= S_STOP;
                  end
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            S_STOP: begin
               if (timer_q == LAST_TICK) begin
                  timer_q <= '0;
                  if (rx_sync_q) begin
                     buf_q <= {buf_q[55:0], byte_q};
                     cnt_q <= cnt_q - 4'd1;
                     if (cnt_q == 4'd1) begin
                        done_q  <= 1'b1;
                        idle_q  <= 1'b1;
                        state_q <= S_IDLE;
                     end else begin
                        state_q <= S_WAIT_START;
                     end
                  end else begin
                     err_q   <= 1'b1;
                     idle_q  <= 1'b1;
                     state_q <= S_IDLE;
                  end
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
               idle_q  <= 1'b1;
            end
         endcase
      end
   end

   assign Buffer = buf_q;
   assign idle   = idle_q;
   assign Done   = done_q;
   assign Err    = err_q;

endmodule
